// File: rtl/wl_pkg.sv
// Shared types and constants for the weight load scheduler.
// Holds the FSM state encoding and the words-per-row helper.
package wl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        DRAIN,
        DONE
    } wl_state_t;

    localparam int unsigned MAX_WORDS = 13;
    localparam int unsigned WEIGHT_W  = 16;
    localparam int unsigned MAX_DIM   = 2 * MAX_WORDS - 1;

    // Each stream word packs two weights, so a row needs ceil(dim/2) words.
    function automatic int unsigned words_per_row(input int unsigned dim);
        return (dim + 1) >> 1;
    endfunction

endpackage

// File: rtl/weight_skew_gen.sv
// Thermometer row-enable generator: while start_i is high, one more row is
// enabled per cycle (row 0 first); clear_i drops all enables and restarts.
module weight_skew_gen
    import wl_pkg::*;
#(
    parameter int unsigned N_ROWS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    output logic [N_ROWS-1:0] row_en_o
);

    localparam int unsigned SKEW_W = ($clog2(N_ROWS) > 4) ? $clog2(N_ROWS) : 4;

    logic [SKEW_W-1:0] skew_cnt_q, skew_cnt_d;
    logic [N_ROWS-1:0] row_en_q, row_en_d;

    always_comb begin
        skew_cnt_d = skew_cnt_q;
        row_en_d   = row_en_q;
        if (clear_i) begin
            skew_cnt_d = '0;
            row_en_d   = '0;
        end else if (start_i) begin
            row_en_d   = row_en_q | (N_ROWS'(1) << skew_cnt_q);
            skew_cnt_d = skew_cnt_q + SKEW_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skew_cnt_q <= '0;
            row_en_q   <= '0;
        end else begin
            skew_cnt_q <= skew_cnt_d;
            row_en_q   <= row_en_d;
        end
    end

    assign row_en_o = row_en_q;

endmodule

// File: rtl/weight_load_sched.sv
// Weight load scheduler: fills each systolic row buffer in turn from the
// stream, releases rows with a one-cycle skew, then waits for all to drain.
module weight_load_sched
    import wl_pkg::*;
#(
    parameter int unsigned N_ROWS = 4,
    parameter int unsigned DATA_W = 2 * WEIGHT_W,
    parameter int unsigned DIM_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  weight_dim_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [N_ROWS-1:0] wb_fifo_en_o,
    input  logic [N_ROWS-1:0] wb_pe_en_i,
    output logic [N_ROWS-1:0] row_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_dim_o
);

    localparam int unsigned ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned CNT_W = ($clog2(MAX_WORDS) > 4) ? $clog2(MAX_WORDS) : 4;

    wl_state_t         state_q, state_d;
    logic [DIM_W-1:0]  dim_q, dim_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ROW_W-1:0]  row_idx_q, row_idx_d;
    logic              drain_arm_q, drain_arm_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_dim_q, err_dim_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [N_ROWS-1:0] wb_fifo_en_q, wb_fifo_en_d;

    logic              dim_ok_c;
    logic [CNT_W-1:0]  word_last_c;
    logic              accept_c;
    logic              row_done_c;
    logic              job_done_c;
    logic [N_ROWS-1:0] skew_row_en;

    assign dim_ok_c    = (weight_dim_i != '0) && (32'(weight_dim_i) <= MAX_DIM);
    assign word_last_c = CNT_W'(words_per_row(32'(dim_q)) - 1);
    assign accept_c    = s_valid_i && (state_q == LOAD);
    assign row_done_c  = (word_cnt_q == word_last_c);
    assign job_done_c  = row_done_c && (row_idx_q == ROW_W'(N_ROWS - 1));

    weight_skew_gen #(
        .N_ROWS (N_ROWS)
    ) u_skew (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (state_q == RELEASE),
        .clear_i  (state_q == DONE),
        .row_en_o (skew_row_en)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d      = state_q;
        dim_d        = dim_q;
        word_cnt_d   = word_cnt_q;
        row_idx_d    = row_idx_q;
        drain_arm_d  = (state_q == DRAIN);
        wb_data_d    = wb_data_q;
        wb_fifo_en_d = '0;
        err_dim_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (dim_ok_c) begin
                        dim_d      = weight_dim_i;
                        word_cnt_d = '0;
                        row_idx_d  = '0;
                        state_d    = LOAD;
                    end else begin
                        err_dim_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept_c) begin
                    wb_data_d    = s_data_i;
                    wb_fifo_en_d = N_ROWS'(1) << row_idx_q;
                    if (row_done_c) begin
                        word_cnt_d = '0;
                        row_idx_d  = row_idx_q + ROW_W'(1);
                        if (job_done_c) begin
                            state_d = RELEASE;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            RELEASE: begin
                // Second-to-last row already on means the last one lands this edge.
                if (skew_row_en[N_ROWS-2]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_arm_q && (wb_pe_en_i == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d = (state_d == LOAD);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            dim_q        <= '0;
            word_cnt_q   <= '0;
            row_idx_q    <= '0;
            drain_arm_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_dim_q    <= 1'b0;
            wb_data_q    <= '0;
            wb_fifo_en_q <= '0;
        end else begin
            state_q      <= state_d;
            dim_q        <= dim_d;
            word_cnt_q   <= word_cnt_d;
            row_idx_q    <= row_idx_d;
            drain_arm_q  <= drain_arm_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_dim_q    <= err_dim_d;
            wb_data_q    <= wb_data_d;
            wb_fifo_en_q <= wb_fifo_en_d;
        end
    end

    assign s_ready_o    = s_ready_q;
    assign wb_data_o    = wb_data_q;
    assign wb_fifo_en_o = wb_fifo_en_q;
    assign row_en_o     = skew_row_en;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_dim_o    = err_dim_q;

endmodule

// File: tb/tb_weight_load_sched.sv
// Self-checking bench for weight_load_sched: job-level reference model,
// start/dim table, hand-written reset and drain sequences, random jobs.
module tb_weight_load_sched;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    weight_dim;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   wb_data;
    logic [N-1:0]  wb_fifo_en;
    logic [N-1:0]  wb_pe_en;
    logic [N-1:0]  row_en;
    logic          busy;
    logic          done;
    logic          err_dim;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] model_data = '0;

    weight_load_sched #(
        .N_ROWS (N),
        .DATA_W (32),
        .DIM_W  (5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .weight_dim_i (weight_dim),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .wb_data_o    (wb_data),
        .wb_fifo_en_o (wb_fifo_en),
        .wb_pe_en_i   (wb_pe_en),
        .row_en_o     (row_en),
        .busy_o       (busy),
        .done_o       (done),
        .err_dim_o    (err_dim)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    function automatic logic [63:0] snap();
        return {20'd0, s_ready, busy, done, err_dim, row_en, wb_fifo_en, wb_data};
    endfunction

    function automatic logic [63:0] pack(input bit r, input bit b, input bit d, input bit e,
                                         input logic [N-1:0] ren, input logic [N-1:0] fen,
                                         input logic [31:0] data);
        return {20'd0, r, b, d, e, ren, fen, data};
    endfunction

    // One complete job; called at a negedge with the DUT idle. Expected
    // behaviour comes from word index k: row = k / W, strobe one cycle later.
    task automatic run_job(input int dim, input int vmode, input int pe_hold,
                           input bit stray, input bit rnd);
        int w, total, k, k_prev, c, l_neg, r_neg, dn;
        bit hs, hs_prev, finished;
        logic [31:0] words[$];
        int strobes[N];
        logic [N-1:0] ren_exp, fen_exp;
        bit ready_exp, busy_exp, done_exp;

        w = (dim + 1) / 2;
        total = N * w;
        for (int i = 0; i < total; i++)
            words.push_back(rnd ? $urandom : {16'(2 * i + 1), 16'(2 * i)});
        for (int i = 0; i < N; i++) strobes[i] = 0;
        k = 0; k_prev = 0; hs_prev = 0; l_neg = -1; r_neg = -1; dn = -1; finished = 0;

        start = 1'b1; weight_dim = 5'(dim); s_valid = 1'b0; wb_pe_en = '1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 3000; c++) begin
            ready_exp = (k < total);
            busy_exp  = (dn < 0) || (c <= dn);
            done_exp  = (c == dn);
            fen_exp   = hs_prev ? (N'(1) << (k_prev / w)) : '0;
            if (hs_prev) model_data = words[k_prev];
            if (l_neg < 0 || c < l_neg || c > dn) ren_exp = '0;
            else if (c - l_neg >= N) ren_exp = '1;
            else ren_exp = (N'(1) << (c - l_neg)) - N'(1);
            check("job_cycle", snap(), pack(ready_exp, busy_exp, done_exp, 1'b0,
                                            ren_exp, fen_exp, model_data));
            for (int i = 0; i < N; i++) if (wb_fifo_en[i]) strobes[i]++;
            if (dn >= 0 && c == dn + 1) begin
                finished = 1;
                break;
            end

            start = stray && (c == 2);
            weight_dim = stray && (c == 2) ? 5'd0 : 5'($urandom);
            hs = 0;
            if (k < total) begin
                case (vmode)
                    0: s_valid = 1'b1;
                    1: s_valid = (c % 3 == 0);
                    default: s_valid = 1'($urandom_range(0, 1));
                endcase
                s_data = words[k];
                if (s_valid) begin
                    hs = 1; k_prev = k; k++;
                    if (k == total) begin
                        l_neg = c + 1;
                        r_neg = l_neg + N;
                        dn = (pe_hold + 1 > 2) ? r_neg + pe_hold + 1 : r_neg + 2;
                    end
                end
            end else begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
            end
            hs_prev = hs;
            if (r_neg < 0 || c < r_neg) wb_pe_en = '1;
            else if (c < r_neg + pe_hold) wb_pe_en = N'(1) << 2;
            else wb_pe_en = '0;
            @(negedge clk);
        end
        if (!finished) check("job_timeout", 64'd0, 64'd1);
        for (int i = 0; i < N; i++) check("strobes_per_row", 64'(strobes[i]), 64'(w));
        start = 1'b0; s_valid = 1'b0; wb_pe_en = '1;
    endtask

    typedef struct { int dim; bit exp_err; } start_vec_t;
    typedef struct { int dim; int vmode; int pe_hold; bit stray; bit rnd; } job_vec_t;

    start_vec_t svec[8];
    job_vec_t   jvec[7];

    initial begin
        svec[0] = '{0, 1};  svec[1] = '{26, 1}; svec[2] = '{31, 1}; svec[3] = '{27, 1};
        svec[4] = '{1, 0};  svec[5] = '{25, 0}; svec[6] = '{24, 0}; svec[7] = '{2, 0};
        jvec[0] = '{3, 0, 0, 0, 0};   // basic job, fixed words
        jvec[1] = '{25, 0, 0, 0, 1};  // max dim, 52 words
        jvec[2] = '{24, 2, 1, 0, 1};  // even dim, random valid
        jvec[3] = '{3, 1, 0, 1, 0};   // 1,0,0 valid pattern + stray start
        jvec[4] = '{1, 1, 2, 0, 1};   // one word per row
        jvec[5] = '{3, 0, 20, 0, 0};  // row 2 holds pe_en for 20 cycles
        jvec[6] = '{2, 2, 0, 1, 1};

        rst = 1'b1; start = 1'b0; weight_dim = '0; s_data = '0; s_valid = 1'b0; wb_pe_en = '1;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", snap(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Start acceptance / dim legality table.
        for (int i = 0; i < 8; i++) begin
            start = 1'b1; weight_dim = 5'(svec[i].dim);
            @(negedge clk);
            start = 1'b0;
            check("start_err", {62'd0, err_dim, busy}, {62'd0, svec[i].exp_err, !svec[i].exp_err});
            check("start_ready", {63'd0, s_ready}, {63'd0, !svec[i].exp_err});
            @(negedge clk);
            check("err_one_cycle", {62'd0, err_dim, busy}, {62'd0, 1'b0, !svec[i].exp_err});
            if (!svec[i].exp_err) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_data = '0;
                check("abort_reset", snap(), 64'd0);
            end
        end

        for (int i = 0; i < 7; i++)
            run_job(jvec[i].dim, jvec[i].vmode, jvec[i].pe_hold, jvec[i].stray, jvec[i].rnd);

        // Reset in the middle of LOAD, then a clean job.
        start = 1'b1; weight_dim = 5'd3;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = {16'(2 * i + 1), 16'(2 * i)};
            @(negedge clk);
        end
        check("strobe_before_reset", {28'd0, wb_fifo_en, wb_data}, {28'd0, 4'b0100, 32'h0009_0008});
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_data = '0;
        check("reset_mid_load", snap(), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_reset", {62'd0, done, busy}, 64'd0);
        end
        run_job(3, 0, 0, 0, 0);

        for (int j = 0; j < 15; j++)
            run_job(int'($urandom_range(1, 25)), 2, int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
